// File: rtl/gimli_stream_buffer_out_fifo_if.sv
// rtl/gimli_stream_buffer_out_fifo_if.sv - word-in / beat-out stream buffer handshake bundle
interface gimli_stream_buffer_out_fifo_if #(
    parameter int DIN_WIDTH       = 128,
    parameter int DIN_SIZE_WIDTH  = 4,
    parameter int DOUT_WIDTH      = 32,
    parameter int DOUT_SIZE_WIDTH = 2,
    parameter int DEPTH_WIDTH     = 2
) ();
    logic [DIN_WIDTH-1:0]                        din;
    logic [DIN_SIZE_WIDTH:0]                     din_size;
    logic                                        din_last;
    logic                                        din_valid;
    logic                                        din_ready;
    logic [DOUT_WIDTH-1:0]                       dout;
    logic [DOUT_SIZE_WIDTH:0]                    dout_size;
    logic                                        dout_valid;
    logic                                        dout_ready;
    logic                                        dout_last;
    logic [DIN_SIZE_WIDTH+DEPTH_WIDTH:0]         size;
    logic [DEPTH_WIDTH:0]                        count;

    // Buffer side: accepts words, produces beats and occupancy.
    modport slave (
        input  din, din_size, din_last, din_valid, dout_ready,
        output din_ready, dout, dout_size, dout_valid, dout_last, size, count
    );

    // Environment side: produces words, consumes beats.
    modport master (
        output din, din_size, din_last, din_valid, dout_ready,
        input  din_ready, dout, dout_size, dout_valid, dout_last, size, count
    );
endinterface

// File: rtl/gimli_stream_buffer_out_fifo.sv
// rtl/gimli_stream_buffer_out_fifo.sv - FIFO of wide words drained as narrow beats
module gimli_stream_buffer_out_fifo #(
    parameter int DIN_WIDTH       = 128,
    parameter int DIN_SIZE_WIDTH  = 4,
    parameter int DOUT_WIDTH      = 32,
    parameter int DOUT_SIZE_WIDTH = 2,
    parameter int DEPTH_WIDTH     = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    gimli_stream_buffer_out_fifo_if.slave bus
);
    localparam int DEPTH = 2 ** DEPTH_WIDTH;
    localparam int RW    = DIN_SIZE_WIDTH + 1;
    localparam int SW    = DIN_SIZE_WIDTH + DEPTH_WIDTH + 1;
    localparam int CW    = DEPTH_WIDTH + 1;
    localparam int OW    = DOUT_SIZE_WIDTH + 1;
    localparam logic [RW-1:0] BEAT_BYTES = RW'(2 ** DOUT_SIZE_WIDTH);

    logic [DIN_WIDTH-1:0]   data_mem [DEPTH];
    logic [RW-1:0]          rem_mem  [DEPTH];
    logic                   last_mem [DEPTH];

    logic [DEPTH_WIDTH-1:0] wr_ptr;
    logic [DEPTH_WIDTH-1:0] rd_ptr;
    logic [CW-1:0]          count_q;
    logic [SW-1:0]          size_q;

    logic                   push;
    logic                   store;
    logic                   beat;
    logic                   pop;
    logic                   head_big;
    logic [RW-1:0]          head_rem;
    logic [RW-1:0]          beat_bytes;

    // Handshake decode and head-beat sizing; empty FIFO forces a zero-size beat.
    always_comb begin
        head_rem   = rem_mem[rd_ptr];
        head_big   = 1'b0;
        beat_bytes = '0;
        if (count_q != '0) begin
            head_big   = head_rem > BEAT_BYTES;
            beat_bytes = head_big ? BEAT_BYTES : head_rem;
        end
        push  = bus.din_valid && bus.din_ready;
        // Empty non-final words carry nothing and are dropped; empty final words still mark the end.
        store = push && ((bus.din_size != '0) || bus.din_last);
        beat  = bus.dout_valid && bus.dout_ready;
        pop   = beat && !head_big;
    end

    assign bus.din_ready  = !rst && (count_q < CW'(DEPTH));
    assign bus.dout_valid = count_q != '0;
    assign bus.dout       = data_mem[rd_ptr][DOUT_WIDTH-1:0];
    assign bus.dout_size  = beat_bytes[OW-1:0];
    assign bus.dout_last  = (count_q != '0) && last_mem[rd_ptr] && !head_big;
    assign bus.size       = size_q;
    assign bus.count      = count_q;

    // Pointers and occupancy counters; reset discards everything buffered.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            size_q  <= '0;
        end else begin
            if (store) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count_q <= count_q + CW'(store) - CW'(pop);
            size_q  <= size_q + (store ? SW'(bus.din_size) : SW'(0))
                              - (beat ? SW'(beat_bytes) : SW'(0));
        end
    end

    // Entry storage: write at the tail, shift the head down one beat when it is not finished.
    // The write slot is always empty, so it never collides with the head being shifted.
    always_ff @(posedge clk) begin
        if (store) begin
            data_mem[wr_ptr] <= bus.din;
            rem_mem[wr_ptr]  <= bus.din_size;
            last_mem[wr_ptr] <= bus.din_last;
        end
        if (beat && head_big) begin
            data_mem[rd_ptr] <= data_mem[rd_ptr] >> DOUT_WIDTH;
            rem_mem[rd_ptr]  <= rem_mem[rd_ptr] - BEAT_BYTES;
        end
    end
endmodule

// File: tb/tb_gimli_stream_buffer_out_fifo.sv
// tb/tb_gimli_stream_buffer_out_fifo.sv - directed and randomised checks of the stream buffer
module tb_gimli_stream_buffer_out_fifo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    byte unsigned exp_q[$];
    int   in_last  = 0;
    int   out_last = 0;

    gimli_stream_buffer_out_fifo_if bus ();

    gimli_stream_buffer_out_fifo dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] word_of(input int i);
        logic [127:0] w;
        for (int j = 0; j < 4; j++) w[32*j +: 32] = 32'hA000_0000 + 32'(i * 16 + j);
        return w;
    endfunction

    // Called at the sampling point before an edge: records pushes and checks beats about to transfer.
    task automatic observe();
        if (bus.din_valid && bus.din_ready) begin
            for (int k = 0; k < int'(bus.din_size); k++) exp_q.push_back(bus.din[8*k +: 8]);
            if (bus.din_last) in_last++;
        end
        if (bus.dout_valid && bus.dout_ready) begin
            for (int k = 0; k < int'(bus.dout_size); k++) begin
                if (exp_q.size() == 0) begin
                    chk("rand_underflow", 1, 0);
                end else begin
                    chk("rand_byte", bus.dout[8*k +: 8], exp_q.pop_front());
                end
            end
            if (bus.dout_last) out_last++;
        end
    endtask

    initial begin
        logic [127:0] w;
        bus.din        = '0;
        bus.din_size   = '0;
        bus.din_last   = 1'b0;
        bus.din_valid  = 1'b0;
        bus.dout_ready = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_din_ready", bus.din_ready, 0);
        chk("rst_dout_valid", bus.dout_valid, 0);
        chk("rst_dout_size", bus.dout_size, 0);
        chk("rst_dout_last", bus.dout_last, 0);
        chk("rst_count", bus.count, 0);
        chk("rst_size", bus.size, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_din_ready", bus.din_ready, 1);

        // One full 16-byte final word -> four 4-byte beats
        bus.dout_ready = 1'b1;
        w = word_of(0);
        bus.din = w; bus.din_size = 5'd16; bus.din_last = 1'b1; bus.din_valid = 1'b1;
        step();
        bus.din_valid = 1'b0;
        chk("w16_count", bus.count, 1);
        chk("w16_size", bus.size, 16);
        chk("w16_valid", bus.dout_valid, 1);
        for (int i = 0; i < 4; i++) begin
            chk("w16_dout", bus.dout, w[32*i +: 32]);
            chk("w16_dsize", bus.dout_size, 4);
            chk("w16_dlast", bus.dout_last, (i == 3));
            step();
        end
        chk("w16_count_end", bus.count, 0);
        chk("w16_valid_end", bus.dout_valid, 0);
        chk("w16_size_end", bus.size, 0);

        // Six-byte final word -> 4 then 2 bytes, zero-filled tail
        bus.din = 128'h0000_0000_0000_0000_0000_6655_4433_2211;
        bus.din_size = 5'd6; bus.din_last = 1'b1; bus.din_valid = 1'b1;
        step();
        bus.din_valid = 1'b0;
        chk("w6_b0_dout", bus.dout, 32'h4433_2211);
        chk("w6_b0_size", bus.dout_size, 4);
        chk("w6_b0_last", bus.dout_last, 0);
        step();
        chk("w6_b1_dout", bus.dout, 32'h0000_6655);
        chk("w6_b1_size", bus.dout_size, 2);
        chk("w6_b1_last", bus.dout_last, 1);
        chk("w6_b1_bufsize", bus.size, 2);
        step();
        chk("w6_count_end", bus.count, 0);

        // Fill to capacity with output stalled
        bus.dout_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.din = word_of(i); bus.din_size = 5'd16; bus.din_last = 1'b0; bus.din_valid = 1'b1;
            step();
            chk("full_count", bus.count, (i < 4) ? i + 1 : 4);
            chk("full_din_ready", bus.din_ready, (i < 3));
        end
        bus.din_valid = 1'b0;
        chk("full_size", bus.size, 64);
        chk("full_dout", bus.dout, 32'hA000_0000);
        step();
        chk("stall_hold_dout", bus.dout, 32'hA000_0000);
        chk("stall_hold_dsize", bus.dout_size, 4);
        bus.dout_ready = 1'b1;
        step();
        bus.dout_ready = 1'b0;
        chk("one_beat_size", bus.size, 60);
        chk("one_beat_count", bus.count, 4);
        chk("one_beat_din_ready", bus.din_ready, 0);
        chk("one_beat_dout", bus.dout, 32'hA000_0001);
        bus.dout_ready = 1'b1;
        step(); step(); step();
        chk("pop_count", bus.count, 3);
        chk("pop_size", bus.size, 48);
        chk("pop_din_ready", bus.din_ready, 1);
        chk("pop_dout", bus.dout, 32'hA000_0010);
        for (int i = 0; i < 12; i++) step();
        chk("drain_count", bus.count, 0);
        chk("drain_size", bus.size, 0);

        // Zero-size words: non-final dropped, final kept as one empty last beat
        bus.din_size = '0; bus.din_last = 1'b0; bus.din_valid = 1'b1;
        step();
        chk("z0_count", bus.count, 0);
        chk("z0_valid", bus.dout_valid, 0);
        bus.din_last = 1'b1;
        step();
        bus.din_valid = 1'b0;
        chk("z1_count", bus.count, 1);
        chk("z1_valid", bus.dout_valid, 1);
        chk("z1_dsize", bus.dout_size, 0);
        chk("z1_dlast", bus.dout_last, 1);
        step();
        chk("z1_count_end", bus.count, 0);
        chk("z1_dlast_end", bus.dout_last, 0);

        // Random push/drain across pointer wrap, compared as a byte stream
        for (int c = 0; c < 400; c++) begin
            bus.din_valid  = (c < 320) && ($urandom_range(0, 3) != 0);
            bus.din        = {$urandom, $urandom, $urandom, $urandom};
            bus.din_size   = 5'($urandom_range(1, 16));
            bus.din_last   = ($urandom_range(0, 3) == 0);
            bus.dout_ready = ($urandom_range(0, 2) != 0);
            chk("rand_size", bus.size, exp_q.size());
            observe();
            step();
        end
        bus.din_valid  = 1'b0;
        bus.dout_ready = 1'b1;
        for (int c = 0; c < 200 && bus.count != 0; c++) begin
            observe();
            step();
        end
        chk("rand_drained", bus.count, 0);
        chk("rand_left", exp_q.size(), 0);
        chk("rand_last_cnt", out_last, in_last);

        // Reset while mid-message with three words buffered
        bus.dout_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.din = word_of(i); bus.din_size = 5'd16; bus.din_last = 1'b0; bus.din_valid = 1'b1;
            step();
        end
        bus.din_valid  = 1'b0;
        bus.dout_ready = 1'b1;
        step();
        bus.dout_ready = 1'b0;
        chk("mid_size", bus.size, 44);
        chk("mid_count", bus.count, 3);
        rst = 1'b1;
        step();
        chk("mrst_count", bus.count, 0);
        chk("mrst_size", bus.size, 0);
        chk("mrst_valid", bus.dout_valid, 0);
        chk("mrst_dsize", bus.dout_size, 0);
        chk("mrst_dlast", bus.dout_last, 0);
        chk("mrst_din_ready", bus.din_ready, 0);
        rst = 1'b0;
        #1;
        chk("mrst_din_ready_after", bus.din_ready, 1);
        bus.dout_ready = 1'b1;
        bus.din = 128'h0000_0000_0000_0000_0000_6655_4433_2211;
        bus.din_size = 5'd6; bus.din_last = 1'b1; bus.din_valid = 1'b1;
        step();
        bus.din_valid = 1'b0;
        chk("new_b0_dout", bus.dout, 32'h4433_2211);
        chk("new_b0_size", bus.dout_size, 4);
        step();
        chk("new_b1_dout", bus.dout, 32'h0000_6655);
        chk("new_b1_last", bus.dout_last, 1);
        step();
        chk("new_count_end", bus.count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/gimli_stream_buffer_out_fifo.md
GIMLI_STREAM_BUFFER_OUT_FIFO -- requirements
Module: gimli_stream_buffer_out_fifo

Interface
REQ-001 SHALL have parameter DIN_WIDTH, default 128, input word width in bits (= 8*2**DIN_SIZE_WIDTH).
REQ-002 SHALL have parameter DIN_SIZE_WIDTH, default 4, log2 of input bytes per word.
REQ-003 SHALL have parameter DOUT_WIDTH, default 32, output beat width in bits (= 8*2**DOUT_SIZE_WIDTH); DIN_WIDTH must be a multiple of DOUT_WIDTH.
REQ-004 SHALL have parameter DOUT_SIZE_WIDTH, default 2, log2 of output bytes per beat.
REQ-005 SHALL have parameter DEPTH_WIDTH, default 2; FIFO depth DEPTH = 2**DEPTH_WIDTH input words.
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 din  in  DIN_WIDTH  input word, byte 0 in bits [7:0].
REQ-009 din_size  in  DIN_SIZE_WIDTH+1  valid bytes in din, 0..2**DIN_SIZE_WIDTH.
REQ-010 din_last  in  1  word ends message.
REQ-011 din_valid / din_ready  in / out  1 / 1  input handshake.
REQ-012 dout  out  DOUT_WIDTH  output beat.
REQ-013 dout_size  out  DOUT_SIZE_WIDTH+1  valid bytes in dout.
REQ-014 dout_valid / dout_ready  out / in  1 / 1  output handshake.
REQ-015 dout_last  out  1  beat ends message.
REQ-016 size  out  DIN_SIZE_WIDTH+DEPTH_WIDTH+1  total bytes buffered.
REQ-017 count  out  DEPTH_WIDTH+1  input words buffered, 0..DEPTH.

Function
REQ-018 Transfer SHALL occur on a rising edge where valid and ready are both 1; input transfers are called pushes, output transfers are called beats.
REQ-019 Words SHALL be stored as DEPTH entries {data, remaining bytes, last} in circular order, with write and read pointers wrapping modulo DEPTH.
REQ-020 din_ready SHALL be 1 iff rst=0 and count<DEPTH, and SHALL have no combinational dependence on dout_ready or din_valid.
REQ-021 dout_valid SHALL be 1 iff count!=0 (registered state only).
REQ-022 Head beat: dout = low DOUT_WIDTH bits of head data; dout_size = min(head remaining, 2**DOUT_SIZE_WIDTH).
REQ-023 Head beat: dout_last = head last AND (head remaining <= 2**DOUT_SIZE_WIDTH).
REQ-024 When the FIFO is empty, dout SHALL be don't-care, while dout_size=0 and dout_last=0.
REQ-025 On a beat with head remaining > 2**DOUT_SIZE_WIDTH: head data SHALL shift right by DOUT_WIDTH with zero fill, and remaining SHALL decrease by 2**DOUT_SIZE_WIDTH.
REQ-026 On a beat with remaining <= 2**DOUT_SIZE_WIDTH, the head entry SHALL be popped and the read pointer advanced.
REQ-027 A push with din_size=0 and din_last=0 SHALL be accepted and discarded (no entry, count unchanged).
REQ-028 A push with din_size=0 and din_last=1 SHALL be stored, and SHALL emit exactly one beat with dout_size=0 and dout_last=1.
REQ-029 Latency: a word pushed into an empty FIFO at edge N SHALL present its first beat from the cycle after edge N.
REQ-030 Push and pop on the same edge SHALL leave count unchanged; at count=DEPTH no push occurs (din_ready=0), even if a pop occurs that edge.
REQ-031 A push at count=DEPTH-1 SHALL drive din_ready to 0 from the next cycle.
REQ-032 size SHALL equal the sum of remaining bytes over all stored entries, updated on the same edge as each push or beat.
REQ-033 An entry that is not the head SHALL hold its data and remaining bytes unchanged until it becomes head.
REQ-034 While dout_valid=1 and dout_ready=0, dout, dout_size and dout_last SHALL hold stable.

Reset
REQ-035 On an edge with rst=1: count=0, size=0, both pointers=0, and all buffered words SHALL be discarded, including mid-message.
REQ-036 During and after the reset edge: dout_valid=0, dout_size=0, dout_last=0; din_ready=0 while rst=1 and 1 from the first cycle with rst=0.
REQ-037 Entry data SHALL not require reset.

Verification
REQ-038 Push one word, 16 bytes, last=1, dout_ready=1 -> four beats of size 4, dout_last only on the 4th, count returns to 0.
REQ-039 Push 6 bytes, last=1 -> beats size 4 then size 2 (upper dout bits of 2nd beat zero), 2nd beat last=1.
REQ-040 dout_ready=0, push 5 words -> 4 accepted, din_ready=0, count=4, size=64; then one beat -> size=60, din_ready stays 0 until a word pops.
REQ-041 Push size 0/last 0 then size 0/last 1 -> first dropped; single beat dout_size=0, dout_last=1.
REQ-042 Continuous push and drain with random valid/ready -> output byte stream equals input, and no beat is lost or duplicated across pointer wrap.
REQ-043 Assert rst with 3 words buffered mid-beat -> next cycle count=0, size=0, dout_valid=0; a new push then emits normally.
